boot_ctrl: RTL and testbench
============================

# boot_ctrl

Run controller for the single-cycle core: streams a program image from the host into the core's instruction ROM over a write port, holds the core in reset while loading, then asserts start. It watches the commit stream until a halt instruction or a cycle timeout, and reports pass/fail, commit count and halt PC. It sits between the simulation host and `Core`, replacing backdoor ROM preload with a cycle-accurate load/run sequence.

## Interface

- `ADDR_W`, 10: ROM word-address width (ROM depth = 2^ADDR_W words).
- `HALT_INST`, 32'h00100073: instruction encoding (ebreak) that ends a run.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `io_load_valid`  in  1  host load beat valid.
- `io_load_ready`  out  1  controller accepts beat.
- `io_load_data`  in  32  instruction word.
- `io_load_last`  in  1  final word of image.
- `io_run`  in  1  host request to start the core.
- `io_clear`  in  1  return from DONE/ERROR to IDLE.
- `io_timeout_limit`  in  32  max run cycles; 0 = no timeout.
- `io_rom_wen`  out  1  ROM write enable.
- `io_rom_waddr`  out  ADDR_W  ROM word address.
- `io_rom_wdata`  out  32  ROM write data.
- `io_core_reset`  out  1  reset to core (active-high).
- `io_in_start`  out  1  core start.
- `io_commit`  in  1  core commit strobe.
- `io_commit_pc`  in  32  committed PC.
- `io_commit_inst`  in  32  committed instruction.
- `io_a0`  in  32  core x10 value.
- `io_state`  out  3  IDLE=0, LOAD=1, ARM=2, RUN=3, DONE=4, ERROR=5.
- `io_pass`  out  1  halted with a0==0.
- `io_timeout`  out  1  run ended by timeout.
- `io_commit_count`  out  32  commits in current run.
- `io_halt_pc`  out  32  PC of halting instruction.

## Operation

- Beat accepted when `io_load_valid & io_load_ready`. `io_load_ready` = 1 in IDLE and LOAD only.
- IDLE: write address counter = 0. An accepted beat moves to LOAD, or to ARM if `last`.
- LOAD: each accepted beat writes the word at the counter, then increments the counter. An accepted `last` beat moves to ARM.
- Overflow: an accepted non-last beat at address 2^ADDR_W−1 is still written, then the block moves to ERROR. There is no wrap.
- ARM: `io_core_reset`=1. When `io_run`=1, go to RUN and clear the cycle counter, commit count, pass, timeout and halt PC. `io_run` is ignored in other states.
- RUN: `io_core_reset`=0, `io_in_start`=1.
  - Each `io_commit` increments the commit count. The cycle counter increments every RUN cycle.
  - Halt: `io_commit & io_commit_inst==HALT_INST`. Goes to DONE; `io_halt_pc`←`io_commit_pc`; `io_pass`←(`io_a0`==0). The halting commit is counted.
  - Timeout: `io_timeout_limit`≠0 and cycle counter == limit−1. Goes to DONE with `io_timeout`=1 and `io_pass`=0.
  - Halt and timeout in the same cycle: halt wins and `io_timeout`=0.
- DONE/ERROR: `io_core_reset`=1, `io_in_start`=0, results held. `io_clear` returns to IDLE and the address counter resets to 0. ROM contents are untouched.
- Counters are 32-bit and saturate at 32'hFFFFFFFF.

## Timing

- ROM write is registered. For a beat accepted in cycle N, `io_rom_wen`/`waddr`/`wdata` are valid in N+1 for exactly one cycle. `io_rom_wen`=0 otherwise.
- The state register updates at the edge after the triggering input. `io_core_reset` and `io_in_start` are decoded from the registered state, so the core sees the change one cycle after `io_run`.
- The last ROM write (cycle after `last` is accepted) completes before or alongside the ARM→RUN edge. RUN therefore begins no earlier than one cycle after the final write is issued.
- Reset values: state IDLE, `io_load_ready`=1, `io_rom_wen`=0, `io_rom_waddr`=0, `io_rom_wdata`=0, `io_core_reset`=1, `io_in_start`=0, `io_pass`=0, `io_timeout`=0, `io_commit_count`=0, `io_halt_pc`=0.
- Reset mid-operation (any state) forces all reset values on the next edge. A pending registered ROM write is dropped.

## Test plan

- Load 4 words 0x13,0x93,0x113,0x00100073 with `last` on the 4th beat, continuous valid → writes at addr 0..3 in cycles 1..4; state ARM; `io_core_reset`=1.
- After load, pulse `io_run`; drive commits PC 0,4,8,12 with 12=HALT, `io_a0`=0 → DONE, `io_pass`=1, `io_commit_count`=4, `io_halt_pc`=12, `io_core_reset`=1.
- `io_timeout_limit`=10, no halt → DONE after exactly 10 RUN cycles, `io_timeout`=1, `io_pass`=0. Halt on cycle 10 with `io_a0`=0 → `io_pass`=1, `io_timeout`=0.
- ADDR_W=2, 5 beats with no `last` → writes 0..3, ERROR after the 4th; `io_load_ready`=0. `io_clear` → IDLE, address 0.
- Halt with `io_a0`=1 → `io_pass`=0. Gapped `io_load_valid` (every other cycle) → addresses still contiguous.
- Assert `reset` during RUN with commit count 7 → next cycle IDLE, count 0, `io_core_reset`=1, `io_in_start`=0.

Source files
------------

// File: rtl/boot_ctrl.sv
// ============================================================================
// boot_ctrl
// ----------------------------------------------------------------------------
// Run controller for the single-cycle core. It streams a program image from
// the host into the core's instruction ROM through a registered write port,
// holds the core in reset while loading, and then releases it with start.
// While the core runs, the controller watches the commit stream until a halt
// instruction retires or a cycle budget expires. It then reports pass/fail,
// the commit count and the halting PC.
//
// Ports
//   clock, reset          sole clock (rising edge), synchronous active-high reset
//   io_load_valid/ready   host load handshake; io_load_data is the word and
//                         io_load_last marks the final word of the image
//   io_run, io_clear      host start request / return from DONE or ERROR
//   io_timeout_limit      max run cycles, 0 disables the timeout
//   io_rom_wen/waddr/wdata registered ROM write port
//   io_core_reset         reset to the core (active-high)
//   io_in_start           start to the core
//   io_commit*, io_a0     commit stream and x10 value from the core
//   io_state              IDLE=0 LOAD=1 ARM=2 RUN=3 DONE=4 ERROR=5
//   io_pass, io_timeout, io_commit_count, io_halt_pc   run results
// ============================================================================
module boot_ctrl #(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] HALT_INST = 32'h00100073
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_load_valid,
   output logic              io_load_ready,
   input  logic [31:0]       io_load_data,
   input  logic              io_load_last,
   input  logic              io_run,
   input  logic              io_clear,
   input  logic [31:0]       io_timeout_limit,
   output logic              io_rom_wen,
   output logic [ADDR_W-1:0] io_rom_waddr,
   output logic [31:0]       io_rom_wdata,
   output logic              io_core_reset,
   output logic              io_in_start,
   input  logic              io_commit,
   input  logic [31:0]       io_commit_pc,
   input  logic [31:0]       io_commit_inst,
   input  logic [31:0]       io_a0,
   output logic [2:0]        io_state,
   output logic              io_pass,
   output logic              io_timeout,
   output logic [31:0]       io_commit_count,
   output logic [31:0]       io_halt_pc
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ARM   = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } stateT;

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [31:0]       SAT_MAX  = 32'hFFFF_FFFF;

   stateT             state;
   stateT             nextState;
   logic [ADDR_W-1:0] addrCnt;
   logic [31:0]       cycleCnt;
   logic              beatAccept;
   logic              haltHit;
   logic              timeoutHit;
   logic              runStart;
   logic              clearReq;

   // Event decode shared by the FSM and the datapath. A halt and a timeout
   // can fire in the same cycle; the datapath gives the halt priority.
   always_comb begin
      beatAccept = io_load_valid & io_load_ready;
      haltHit    = (state == RUN) & io_commit & (io_commit_inst == HALT_INST);
      timeoutHit = (state == RUN) & (io_timeout_limit != 32'd0) &
                   (cycleCnt == io_timeout_limit - 32'd1);
      runStart   = (state == ARM) & io_run;
      clearReq   = ((state == DONE) | (state == ERROR)) & io_clear;
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A non-last beat at the top ROM address is still
   // written but ends the load in ERROR, since there is nowhere to put the
   // next word and wrapping would silently corrupt the image.
   always_comb begin
      nextState = state;
      case (state)
         IDLE, LOAD: begin
            if (beatAccept) begin
               if (io_load_last) begin
                  nextState = ARM;
               end else if (addrCnt == ADDR_MAX) begin
                  nextState = ERROR;
               end else begin
                  nextState = LOAD;
               end
            end
         end
         ARM: begin
            if (io_run) begin
               nextState = RUN;
            end
         end
         RUN: begin
            if (haltHit || timeoutHit) begin
               nextState = DONE;
            end
         end
         DONE, ERROR: begin
            if (io_clear) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Output decode from the registered state only, so the core sees reset
   // and start change one cycle after the host's request.
   always_comb begin
      io_load_ready = 1'b0;
      io_core_reset = 1'b1;
      io_in_start   = 1'b0;
      io_state      = state;
      if ((state == IDLE) || (state == LOAD)) begin
         io_load_ready = 1'b1;
      end
      if (state == RUN) begin
         io_core_reset = 1'b0;
         io_in_start   = 1'b1;
      end
   end

   // Load datapath: the ROM write is registered, so an accepted beat shows up
   // on the write port for exactly the following cycle. The address counter
   // never wraps; the FSM leaves for ERROR before that could matter.
   always_ff @(posedge clock) begin
      if (reset) begin
         addrCnt      <= '0;
         io_rom_wen   <= 1'b0;
         io_rom_waddr <= '0;
         io_rom_wdata <= 32'd0;
      end else begin
         io_rom_wen <= beatAccept;
         if (beatAccept) begin
            io_rom_waddr <= addrCnt;
            io_rom_wdata <= io_load_data;
            if (addrCnt != ADDR_MAX) begin
               addrCnt <= addrCnt + ADDR_W'(1);
            end
         end
         if (clearReq) begin
            addrCnt <= '0;
         end
      end
   end

   // Run datapath: results are cleared when the run starts and then held
   // through DONE/ERROR until the next run. Both counters saturate.
   always_ff @(posedge clock) begin
      if (reset) begin
         cycleCnt        <= 32'd0;
         io_commit_count <= 32'd0;
         io_pass         <= 1'b0;
         io_timeout      <= 1'b0;
         io_halt_pc      <= 32'd0;
      end else if (runStart) begin
         cycleCnt        <= 32'd0;
         io_commit_count <= 32'd0;
         io_pass         <= 1'b0;
         io_timeout      <= 1'b0;
         io_halt_pc      <= 32'd0;
      end else if (state == RUN) begin
         if (cycleCnt != SAT_MAX) begin
            cycleCnt <= cycleCnt + 32'd1;
         end
         if (io_commit && (io_commit_count != SAT_MAX)) begin
            io_commit_count <= io_commit_count + 32'd1;
         end
         if (haltHit) begin
            io_halt_pc <= io_commit_pc;
            io_pass    <= (io_a0 == 32'd0);
            io_timeout <= 1'b0;
         end else if (timeoutHit) begin
            io_pass    <= 1'b0;
            io_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_boot_ctrl.sv
// ============================================================================
// tb_boot_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for boot_ctrl (ADDR_W=2 so overflow is reachable). The
// stimulus pushes the expected ROM writes and run results into queues; a
// monitor on the falling edge pops and compares whenever the DUT presents a
// ROM write or enters DONE/ERROR.
// ============================================================================
module tb_boot_ctrl;

   localparam int          AW   = 2;
   localparam logic [31:0] HALT = 32'h00100073;

   logic          clock;
   logic          reset;
   logic          io_load_valid;
   logic          io_load_ready;
   logic [31:0]   io_load_data;
   logic          io_load_last;
   logic          io_run;
   logic          io_clear;
   logic [31:0]   io_timeout_limit;
   logic          io_rom_wen;
   logic [AW-1:0] io_rom_waddr;
   logic [31:0]   io_rom_wdata;
   logic          io_core_reset;
   logic          io_in_start;
   logic          io_commit;
   logic [31:0]   io_commit_pc;
   logic [31:0]   io_commit_inst;
   logic [31:0]   io_a0;
   logic [2:0]    io_state;
   logic          io_pass;
   logic          io_timeout;
   logic [31:0]   io_commit_count;
   logic [31:0]   io_halt_pc;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cycle;
   } writeT;

   typedef struct {
      logic [2:0]  state;
      logic        pass;
      logic        timeout;
      logic [31:0] count;
      logic [31:0] haltPc;
      int          cycle;
   } resultT;

   writeT      romQ[$];
   resultT     resQ[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;
   int         runCyc;
   logic [2:0] prevState = 3'd0;

   boot_ctrl #(.ADDR_W(AW), .HALT_INST(HALT)) dut (
      .clock            (clock),
      .reset            (reset),
      .io_load_valid    (io_load_valid),
      .io_load_ready    (io_load_ready),
      .io_load_data     (io_load_data),
      .io_load_last     (io_load_last),
      .io_run           (io_run),
      .io_clear         (io_clear),
      .io_timeout_limit (io_timeout_limit),
      .io_rom_wen       (io_rom_wen),
      .io_rom_waddr     (io_rom_waddr),
      .io_rom_wdata     (io_rom_wdata),
      .io_core_reset    (io_core_reset),
      .io_in_start      (io_in_start),
      .io_commit        (io_commit),
      .io_commit_pc     (io_commit_pc),
      .io_commit_inst   (io_commit_inst),
      .io_a0            (io_a0),
      .io_state         (io_state),
      .io_pass          (io_pass),
      .io_timeout       (io_timeout),
      .io_commit_count  (io_commit_count),
      .io_halt_pc       (io_halt_pc)
   );

   // Free-running clock and a cycle index used to time expected events.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive one load beat for a cycle and record the write it must produce
   // in the following cycle.
   task automatic applyStimulus(input logic [31:0] data, input logic last,
                                input logic [31:0] addr);
      writeT w;
      io_load_valid = 1'b1;
      io_load_data  = data;
      io_load_last  = last;
      w.addr  = addr;
      w.data  = data;
      w.cycle = cyc + 1;
      romQ.push_back(w);
      tick();
   endtask

   task automatic commitBeat(input logic [31:0] pc, input logic [31:0] inst);
      io_commit      = 1'b1;
      io_commit_pc   = pc;
      io_commit_inst = inst;
      tick();
   endtask

   task automatic expectResult(input logic [2:0] st, input logic pass,
                               input logic tmo, input logic [31:0] count,
                               input logic [31:0] pc, input int at);
      resultT r;
      r.state   = st;
      r.pass    = pass;
      r.timeout = tmo;
      r.count   = count;
      r.haltPc  = pc;
      r.cycle   = at;
      resQ.push_back(r);
   endtask

   task automatic pulseClear();
      io_clear = 1'b1;
      tick();
      io_clear = 1'b0;
      checkOutput("clear_to_idle", 32'(io_state), 32'd0);
   endtask

   // Monitor: consumes the scoreboard queues whenever the DUT shows a ROM
   // write or enters a terminal state.
   always @(negedge clock) begin : monitor
      writeT  w;
      resultT r;
      if (io_rom_wen === 1'b1) begin
         if (romQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%08h at cycle %0d, expected no write",
                     io_rom_waddr, io_rom_wdata, cyc);
         end else begin
            w = romQ.pop_front();
            checkOutput("rom_waddr", 32'(io_rom_waddr), w.addr);
            checkOutput("rom_wdata", io_rom_wdata, w.data);
            checkOutput("rom_wcycle", 32'(cyc), 32'(w.cycle));
         end
      end
      if ((io_state != prevState) && ((io_state == 3'd4) || (io_state == 3'd5))) begin
         if (resQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_end: got state=%0d at cycle %0d, expected none", io_state, cyc);
         end else begin
            r = resQ.pop_front();
            checkOutput("end_state", 32'(io_state), 32'(r.state));
            checkOutput("end_cycle", 32'(cyc), 32'(r.cycle));
            checkOutput("pass", 32'(io_pass), 32'(r.pass));
            checkOutput("timeout", 32'(io_timeout), 32'(r.timeout));
            checkOutput("commit_count", io_commit_count, r.count);
            checkOutput("halt_pc", io_halt_pc, r.haltPc);
            checkOutput("end_core_reset", 32'(io_core_reset), 32'd1);
            checkOutput("end_in_start", 32'(io_in_start), 32'd0);
         end
      end
      prevState <= io_state;
   end

   initial begin
      reset            = 1'b1;
      io_load_valid    = 1'b0;
      io_load_data     = 32'd0;
      io_load_last     = 1'b0;
      io_run           = 1'b0;
      io_clear         = 1'b0;
      io_timeout_limit = 32'd0;
      io_commit        = 1'b0;
      io_commit_pc     = 32'd0;
      io_commit_inst   = 32'd0;
      io_a0            = 32'd0;
      tick();
      tick();

      // Reset values
      checkOutput("rst_state", 32'(io_state), 32'd0);
      checkOutput("rst_ready", 32'(io_load_ready), 32'd1);
      checkOutput("rst_wen", 32'(io_rom_wen), 32'd0);
      checkOutput("rst_waddr", 32'(io_rom_waddr), 32'd0);
      checkOutput("rst_wdata", io_rom_wdata, 32'd0);
      checkOutput("rst_core_reset", 32'(io_core_reset), 32'd1);
      checkOutput("rst_in_start", 32'(io_in_start), 32'd0);
      checkOutput("rst_pass", 32'(io_pass), 32'd0);
      checkOutput("rst_timeout", 32'(io_timeout), 32'd0);
      checkOutput("rst_count", io_commit_count, 32'd0);
      checkOutput("rst_halt_pc", io_halt_pc, 32'd0);
      reset = 1'b0;

      // Continuous 4-word load ending in ARM
      applyStimulus(32'h13, 1'b0, 32'd0);
      applyStimulus(32'h93, 1'b0, 32'd1);
      applyStimulus(32'h113, 1'b0, 32'd2);
      applyStimulus(HALT, 1'b1, 32'd3);
      io_load_valid = 1'b0;
      io_load_last  = 1'b0;
      checkOutput("arm_state", 32'(io_state), 32'd2);
      checkOutput("arm_core_reset", 32'(io_core_reset), 32'd1);
      checkOutput("arm_ready", 32'(io_load_ready), 32'd0);

      // Run to halt at PC 12 with a0 == 0
      runCyc = cyc;
      expectResult(3'd4, 1'b1, 1'b0, 32'd4, 32'd12, runCyc + 5);
      io_run = 1'b1;
      tick();
      io_run = 1'b0;
      checkOutput("run_state", 32'(io_state), 32'd3);
      checkOutput("run_in_start", 32'(io_in_start), 32'd1);
      checkOutput("run_core_reset", 32'(io_core_reset), 32'd0);
      commitBeat(32'd0, 32'h13);
      commitBeat(32'd4, 32'h93);
      commitBeat(32'd8, 32'h113);
      commitBeat(32'd12, HALT);
      io_commit = 1'b0;
      tick();
      tick();
      checkOutput("done_held_count", io_commit_count, 32'd4);
      pulseClear();

      // Timeout after exactly 10 RUN cycles
      applyStimulus(32'h13, 1'b1, 32'd0);
      io_load_valid    = 1'b0;
      io_load_last     = 1'b0;
      io_timeout_limit = 32'd10;
      runCyc = cyc;
      expectResult(3'd4, 1'b0, 1'b1, 32'd0, 32'd0, runCyc + 11);
      io_run = 1'b1;
      tick();
      io_run = 1'b0;
      repeat (9) tick();
      checkOutput("pre_timeout_state", 32'(io_state), 32'd3);
      repeat (3) tick();
      pulseClear();

      // Halt in the same cycle as the timeout: halt wins
      applyStimulus(32'h13, 1'b1, 32'd0);
      io_load_valid = 1'b0;
      io_load_last  = 1'b0;
      runCyc = cyc;
      expectResult(3'd4, 1'b1, 1'b0, 32'd1, 32'h24, runCyc + 11);
      io_run = 1'b1;
      tick();
      io_run = 1'b0;
      repeat (9) tick();
      commitBeat(32'h24, HALT);
      io_commit = 1'b0;
      io_timeout_limit = 32'd0;
      repeat (2) tick();
      pulseClear();

      // Gapped load, then halt with a0 == 1
      applyStimulus(32'h13, 1'b0, 32'd0);
      io_load_valid = 1'b0;
      tick();
      applyStimulus(32'h93, 1'b0, 32'd1);
      io_load_valid = 1'b0;
      tick();
      applyStimulus(32'h113, 1'b1, 32'd2);
      io_load_valid = 1'b0;
      io_load_last  = 1'b0;
      checkOutput("gap_arm_state", 32'(io_state), 32'd2);
      runCyc = cyc;
      expectResult(3'd4, 1'b0, 1'b0, 32'd2, 32'd4, runCyc + 3);
      io_a0  = 32'd1;
      io_run = 1'b1;
      tick();
      io_run = 1'b0;
      commitBeat(32'd0, 32'h13);
      commitBeat(32'd4, HALT);
      io_commit = 1'b0;
      io_a0     = 32'd0;
      repeat (2) tick();
      pulseClear();

      // Overflow: 4 non-last beats fill the ROM, the 5th is refused
      runCyc = cyc;
      expectResult(3'd5, 1'b0, 1'b0, 32'd2, 32'd4, runCyc + 4);
      applyStimulus(32'hA0, 1'b0, 32'd0);
      applyStimulus(32'hA1, 1'b0, 32'd1);
      applyStimulus(32'hA2, 1'b0, 32'd2);
      applyStimulus(32'hA3, 1'b0, 32'd3);
      io_load_data = 32'hA4;
      checkOutput("ovf_state", 32'(io_state), 32'd5);
      checkOutput("ovf_ready", 32'(io_load_ready), 32'd0);
      tick();
      io_load_valid = 1'b0;
      tick();
      pulseClear();

      // Address counter restarts at 0 after clear
      applyStimulus(32'hB0, 1'b1, 32'd0);
      io_load_valid = 1'b0;
      io_load_last  = 1'b0;
      checkOutput("reload_arm_state", 32'(io_state), 32'd2);

      // Reset in the middle of a run with 7 commits
      io_run = 1'b1;
      tick();
      io_run = 1'b0;
      for (int i = 0; i < 7; i++) begin
         commitBeat(32'(i * 4), 32'h13);
      end
      io_commit = 1'b0;
      checkOutput("mid_run_count", io_commit_count, 32'd7);
      checkOutput("mid_run_in_start", 32'(io_in_start), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midrst_state", 32'(io_state), 32'd0);
      checkOutput("midrst_count", io_commit_count, 32'd0);
      checkOutput("midrst_core_reset", 32'(io_core_reset), 32'd1);
      checkOutput("midrst_in_start", 32'(io_in_start), 32'd0);
      checkOutput("midrst_ready", 32'(io_load_ready), 32'd1);
      repeat (3) tick();

      checkOutput("rom_queue_drained", 32'(romQ.size()), 32'd0);
      checkOutput("result_queue_drained", 32'(resQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
